// File: rtl/mips_pkg.sv
// mips_pkg: memory access op codes, byte-enable constants and W-side load register layout
// shared by the data-memory lane unit and its load extender.
package mips_pkg;
   localparam logic [2:0] MEM_OP_WORD  = 3'd0;
   localparam logic [2:0] MEM_OP_HALFS = 3'd1;
   localparam logic [2:0] MEM_OP_HALFU = 3'd2;
   localparam logic [2:0] MEM_OP_BYTES = 3'd3;
   localparam logic [2:0] MEM_OP_BYTEU = 3'd4;
   localparam logic [3:0] BYTEEN_NONE  = 4'b0000;

   typedef struct packed {
      logic        load_valid;
      logic [4:0]  rd_idx;
      logic [2:0]  op;
      logic [1:0]  off;
      logic [31:0] raw;
      logic        exc;
   } w_reg_t;

   function automatic logic is_legal_mem_op(input logic [2:0] op);
      return op <= MEM_OP_BYTEU;
   endfunction
endpackage

// File: rtl/load_ext.sv
// load_ext: selects the addressed byte/halfword of a loaded word and sign- or zero-extends it.
module load_ext
   import mips_pkg::*;
(
   input  logic [31:0] i_raw,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_op,
   output logic [31:0] o_data
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_raw[{i_off, 3'b000} +: 8];
   assign w_half = i_raw[{i_off[1], 4'b0000} +: 16];
   assign o_data = (i_op == MEM_OP_BYTES) ? {{24{w_byte[7]}}, w_byte} :
                   (i_op == MEM_OP_BYTEU) ? {24'd0, w_byte} :
                   (i_op == MEM_OP_HALFS) ? {{16{w_half[15]}}, w_half} :
                   (i_op == MEM_OP_HALFU) ? {16'd0, w_half} : i_raw;
endmodule

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: store-side byte-lane steering and byte enables in M, plus the W-side load
// register feeding load_ext; flags misaligned and illegal accesses.
module dm_lane_unit
   import mips_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter bit EXC_ON_MISALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              M_valid,
   input  logic              M_mem_wr,
   input  logic              M_mem_rd,
   input  logic [2:0]        M_mem_op,
   input  logic [ADDR_W-1:0] M_addr,
   input  logic [31:0]       M_wdata,
   input  logic [4:0]        M_rd_idx,
   input  logic              W_stall,
   input  logic              W_flush,
   output logic [ADDR_W-1:0] m_data_addr,
   output logic [31:0]       m_data_wdata,
   output logic [3:0]        m_data_byteen,
   input  logic [31:0]       m_data_rdata,
   output logic              M_addr_exc,
   output logic              W_load_valid,
   output logic [4:0]        W_rd_idx,
   output logic [31:0]       W_load_data,
   output logic              W_addr_exc
);
   logic        w_is_word, w_is_half, w_illegal, w_misalign, w_suppress;
   logic [1:0]  w_off;
   logic [31:0] w_ext;
   w_reg_t      r_w;

   assign w_is_word  = M_mem_op == MEM_OP_WORD;
   assign w_is_half  = (M_mem_op == MEM_OP_HALFS) | (M_mem_op == MEM_OP_HALFU);
   assign w_illegal  = !is_legal_mem_op(M_mem_op) | (M_mem_wr & M_mem_rd);
   assign w_misalign = (w_is_word & |M_addr[1:0]) | (w_is_half & M_addr[0]);
   assign w_suppress = w_illegal | (EXC_ON_MISALIGN & w_misalign);
   // Without misalign exceptions the access is force-aligned to its natural boundary.
   assign w_off = EXC_ON_MISALIGN ? M_addr[1:0] :
                  w_is_word ? 2'b00 :
                  w_is_half ? {M_addr[1], 1'b0} : M_addr[1:0];

   assign m_data_addr   = {M_addr[ADDR_W-1:2], 2'b00};
   assign M_addr_exc    = M_valid & (M_mem_wr | M_mem_rd) & w_suppress;
   assign m_data_wdata  = w_is_word ? M_wdata :
                          w_is_half ? {2{M_wdata[15:0]}} : {4{M_wdata[7:0]}};
   assign m_data_byteen = (!M_valid | !M_mem_wr | w_suppress) ? BYTEEN_NONE :
                          w_is_word ? 4'b1111 :
                          w_is_half ? (w_off[1] ? 4'b1100 : 4'b0011) :
                          4'b0001 << w_off;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_w <= '0;
      end else if (W_flush) begin
         r_w.load_valid <= 1'b0;
         r_w.rd_idx     <= '0;
         r_w.raw        <= '0;
         r_w.exc        <= 1'b0;
      end else if (!W_stall) begin
         r_w.load_valid <= M_valid & M_mem_rd & !M_addr_exc;
         r_w.rd_idx     <= M_rd_idx;
         r_w.op         <= M_mem_op;
         r_w.off        <= w_off;
         r_w.raw        <= m_data_rdata;
         r_w.exc        <= M_addr_exc;
      end
   end

   load_ext u_load_ext (
      .i_raw  (r_w.raw),
      .i_off  (r_w.off),
      .i_op   (r_w.op),
      .o_data (w_ext)
   );

   assign W_load_valid = r_w.load_valid;
   assign W_rd_idx     = r_w.rd_idx;
   assign W_addr_exc   = r_w.exc;
   assign W_load_data  = r_w.load_valid ? w_ext : 32'd0;
endmodule

// File: tb/tb_dm_lane_unit.sv
// tb_dm_lane_unit: directed vectors; M-side outputs checked in the cycle they are driven,
// W-side expectations queued per cycle and checked by an independent monitor.
module tb_dm_lane_unit;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        m_valid = 1'b0, m_wr = 1'b0, m_rd = 1'b0;
   logic [2:0]  m_op = 3'd0;
   logic [31:0] m_addr = '0, m_wd = '0, rdata = '0;
   logic [4:0]  m_idx = '0;
   logic        w_stall = 1'b0, w_flush = 1'b0;
   logic [31:0] d_addr, d_wdata, w_data;
   logic [3:0]  d_be;
   logic        m_exc, w_valid, w_exc;
   logic [4:0]  w_idx;

   typedef struct {
      int          id;
      logic        v;
      logic [4:0]  idx;
      logic [31:0] d;
      logic        exc;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0, n_bad = 0, n_id = 0;

   always #5 clk = ~clk;

   dm_lane_unit dut (
      .clk(clk), .reset_n(reset_n),
      .M_valid(m_valid), .M_mem_wr(m_wr), .M_mem_rd(m_rd), .M_mem_op(m_op),
      .M_addr(m_addr), .M_wdata(m_wd), .M_rd_idx(m_idx),
      .W_stall(w_stall), .W_flush(w_flush),
      .m_data_addr(d_addr), .m_data_wdata(d_wdata), .m_data_byteen(d_be),
      .m_data_rdata(rdata), .M_addr_exc(m_exc),
      .W_load_valid(w_valid), .W_rd_idx(w_idx), .W_load_data(w_data), .W_addr_exc(w_exc)
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic mcyc(input logic v, input logic wr, input logic rd, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input logic [4:0] idx, input logic st, input logic fl,
                       input logic ev, input logic [4:0] eidx, input logic [31:0] ed,
                       input logic eexc);
      @(negedge clk);
      m_valid = v; m_wr = wr; m_rd = rd; m_op = op; m_addr = a; m_wd = wd;
      rdata = rdat; m_idx = idx; w_stall = st; w_flush = fl;
      q.push_back('{n_id, ev, eidx, ed, eexc});
      n_id++;
   endtask

   task automatic chk_m(input string n, input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] a, input logic ex);
      #1;
      chk({n, ".byteen"}, {28'd0, d_be}, {28'd0, be});
      chk({n, ".wdata"}, d_wdata, wd);
      chk({n, ".addr"}, d_addr, a);
      chk({n, ".exc"}, {31'd0, m_exc}, {31'd0, ex});
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk($sformatf("W%0d.valid", e.id), {31'd0, w_valid}, {31'd0, e.v});
         chk($sformatf("W%0d.rd_idx", e.id), {27'd0, w_idx}, {27'd0, e.idx});
         chk($sformatf("W%0d.data", e.id), w_data, e.d);
         chk($sformatf("W%0d.exc", e.id), {31'd0, w_exc}, {31'd0, e.exc});
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst.valid", {31'd0, w_valid}, 32'd0);
      chk("rst.data", w_data, 32'd0);
      chk("rst.exc", {31'd0, w_exc}, 32'd0);
      // Stores and loads: v wr rd op addr wdata rdata idx stall flush | W expectation
      mcyc(1, 1, 0, 3'd3, 32'h0000_1003, 32'h1234_56AB, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_m("sb", 4'b1000, 32'hABAB_ABAB, 32'h0000_1000, 0);
      mcyc(1, 0, 1, 3'd3, 32'h0000_2002, 0, 32'h00F0_0000, 5, 0, 0, 1, 5, 32'hFFFF_FFF0, 0);
      chk_m("lb", 4'b0000, 32'h0000_0000, 32'h0000_2000, 0);
      mcyc(1, 0, 1, 3'd4, 32'h0000_2002, 0, 32'h00F0_0000, 6, 0, 0, 1, 6, 32'h0000_00F0, 0);
      mcyc(1, 0, 1, 3'd1, 32'h0000_3002, 0, 32'h8001_7FFF, 7, 0, 0, 1, 7, 32'hFFFF_8001, 0);
      mcyc(1, 0, 1, 3'd2, 32'h0000_3002, 0, 32'h8001_7FFF, 8, 0, 0, 1, 8, 32'h0000_8001, 0);
      mcyc(1, 0, 1, 3'd0, 32'h0000_0100, 0, 32'hDEAD_BEEF, 2, 0, 0, 1, 2, 32'hDEAD_BEEF, 0);
      mcyc(1, 1, 0, 3'd0, 32'h0000_0006, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 0, 1);
      chk_m("sw_mis", 4'b0000, 32'h1111_2222, 32'h0000_0004, 1);
      mcyc(1, 1, 0, 3'd1, 32'h0000_0002, 32'hCAFE_1234, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_m("sh", 4'b1100, 32'h1234_1234, 32'h0000_0000, 0);
      mcyc(1, 0, 1, 3'd5, 32'h0000_0000, 0, 32'h5555_5555, 7, 0, 0, 0, 7, 0, 1);
      chk_m("illegal_op", 4'b0000, 32'h0000_0000, 32'h0000_0000, 1);
      mcyc(1, 1, 1, 3'd0, 32'h0000_0010, 32'h1234_5678, 0, 4, 0, 0, 0, 4, 0, 1);
      chk_m("wr_rd", 4'b0000, 32'h1234_5678, 32'h0000_0010, 1);
      mcyc(1, 0, 1, 3'd1, 32'h0000_0001, 0, 32'h7777_7777, 3, 0, 0, 0, 3, 0, 1);
      chk_m("lh_mis", 4'b0000, 32'h0000_0000, 32'h0000_0000, 1);
      mcyc(0, 1, 0, 3'd3, 32'h0000_0001, 32'h0000_00C3, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_m("bubble_sb", 4'b0000, 32'hC3C3_C3C3, 32'h0000_0000, 0);
      mcyc(1, 1, 0, 3'd4, 32'hFFFF_FFFF, 32'h0000_005A, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_m("sb_wrap", 4'b1000, 32'h5A5A_5A5A, 32'hFFFF_FFFC, 0);
      // Held load under stall, then flush wins over stall.
      mcyc(1, 0, 1, 3'd3, 32'h0000_0041, 0, 32'h0000_8000, 9, 0, 0, 1, 9, 32'hFFFF_FF80, 0);
      for (int i = 0; i < 3; i++)
         mcyc(1, 0, 1, 3'd0, 32'h0000_0080, 0, 32'h1111_1111, 3, 1, 0, 1, 9, 32'hFFFF_FF80, 0);
      mcyc(1, 0, 1, 3'd0, 32'h0000_0080, 0, 32'h1111_1111, 3, 1, 1, 0, 0, 0, 0);
      // Asynchronous reset between edges while a load sits in W.
      mcyc(1, 0, 1, 3'd4, 32'h0000_0003, 0, 32'hAB00_0000, 31, 0, 0, 1, 31, 32'h0000_00AB, 0);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst.valid", {31'd0, w_valid}, 32'd0);
      chk("arst.rd_idx", {27'd0, w_idx}, 32'd0);
      chk("arst.data", w_data, 32'd0);
      chk("arst.exc", {31'd0, w_exc}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_valid = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
